// File: rtl/spi_ram_pkg.sv
// Shared command encoding and word widths for the SPI slave and the command RAM.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package spi_ram_pkg;

  localparam int CMD_W  = 2;
  localparam int WORD_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_core.sv
// Single-port byte array with a registered read port.
// Latency: write and read both take effect on the enabling clock edge; rdata holds until the next read.
// Backpressure: none; callers must only enable with an in-range address.
module spi_ram_core
  import spi_ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents survive reset, so the array has no reset term.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write on we, capture read data on re; the read register holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// Decodes 10-bit SPI command words into address/data operations on a byte RAM (optional ADDR_AUTOINC_EN).
// Latency: read data and tx_valid appear one cycle after the RD_DATA edge and hold until the next command.
// Backpressure: none; every rx_valid pulse is accepted.
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  cmd_e                 cmd;
  logic [ADDR_SIZE-1:0] din_addr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] core_addr;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 core_we;
  logic                 core_re;
  logic [DATA_W-1:0]    core_rdata;
  logic                 rd_oor;

  assign cmd         = cmd_e'(din[WORD_W-1:DATA_W]);
  assign din_addr    = din[ADDR_SIZE-1:0];
  assign wr_in_range = int'(wr_addr) < MEM_DEPTH;
  assign rd_in_range = int'(rd_addr) < MEM_DEPTH;

`ifdef ADDR_AUTOINC_EN
  // Out-of-range addresses also wrap to 0 so the pointer re-enters the array.
  function automatic logic [ADDR_SIZE-1:0] inc_wrap(input logic [ADDR_SIZE-1:0] a);
    if (int'(a) >= MEM_DEPTH - 1) return '0;
    return a + ADDR_SIZE'(1);
  endfunction
`endif

  // Steer the single RAM port: reads use rd_addr, everything else uses wr_addr; out-of-range accesses never reach the array.
  always_comb begin
    core_we   = 1'b0;
    core_re   = 1'b0;
    core_addr = wr_addr;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_DATA: core_we = wr_in_range;
        CMD_RD_DATA: begin
          core_re   = rd_in_range;
          core_addr = rd_addr;
        end
        default: ;
      endcase
    end
  end

  // Address registers, tx_valid and the out-of-range read flag update on each accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else if (rx_valid) begin
      tx_valid <= (cmd == CMD_RD_DATA);
      case (cmd)
        CMD_WR_ADDR: wr_addr <= din_addr;
        CMD_WR_DATA: begin
`ifdef ADDR_AUTOINC_EN
          wr_addr <= inc_wrap(wr_addr);
`endif
        end
        CMD_RD_ADDR: rd_addr <= din_addr;
        CMD_RD_DATA: begin
          rd_oor <= !rd_in_range;
`ifdef ADDR_AUTOINC_EN
          rd_addr <= inc_wrap(rd_addr);
`endif
        end
        default: ;
      endcase
    end
  end

  // Gating by tx_valid gives dout=0 the instant reset asserts, without resetting the RAM read register.
  assign dout = (tx_valid && !rd_oor) ? core_rdata : '0;

  spi_ram_core #(
    .DEPTH(MEM_DEPTH),
    .AW   (ADDR_SIZE)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .re   (core_re),
    .addr (core_addr),
    .wdata(din[DATA_W-1:0]),
    .rdata(core_rdata)
  );

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Scoreboard bench for spi_cmd_ram: a 256-deep and a 200-deep instance share one command stream.
// Latency: expected responses are checked on the falling edge after each accepted command.
// Backpressure: none; commands are issued with one idle cycle between them.
module tb_spi_cmd_ram;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout, dout2;
  logic       tx_valid, tx_valid2;

  typedef struct {
    logic       tv;
    logic [7:0] d;
    logic       tv2;
    logic [7:0] d2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic acc = 1'b0;

  always #5 clk = ~clk;

  spi_cmd_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .reset(reset), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid)
  );

  spi_cmd_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut2 (
    .clk(clk), .reset(reset), .din(din), .rx_valid(rx_valid),
    .dout(dout2), .tx_valid(tx_valid2)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command and queue the response both instances must show after it.
  task automatic send(input logic [1:0] c, input logic [7:0] b,
                      input logic tv, input logic [7:0] d,
                      input logic tv2, input logic [7:0] d2);
    exp_t e;
    @(negedge clk);
    e.tv = tv; e.d = d; e.tv2 = tv2; e.d2 = d2;
    sb.push_back(e);
    din      = {c, b};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    din      = '0;
  endtask

  // Note which edges accepted a command.
  always @(posedge clk) acc <= rx_valid && reset;

  // Monitor: after each accepted command, pop the expectation and compare both instances.
  always @(negedge clk) begin
    if (acc) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: response with no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_valid", {7'd0, tx_valid}, {7'd0, e.tv});
        if (e.tv) check("dout", dout, e.d);
        check("tx_valid2", {7'd0, tx_valid2}, {7'd0, e.tv2});
        if (e.tv2) check("dout2", dout2, e.d2);
      end
    end
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_tv", {7'd0, tx_valid}, 8'h00);
    check("rst_dout2", dout2, 8'h00);
    check("rst_tv2", {7'd0, tx_valid2}, 8'h00);
    reset = 1'b1;

    // Preload locations used later.
    send(CMD_WR_ADDR, 8'h00, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h77, 0, 0, 0, 0);
    send(CMD_WR_ADDR, 8'h28, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h3C, 0, 0, 0, 0);
    send(CMD_WR_ADDR, 8'h13, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h5A, 0, 0, 0, 0);

    // Basic write then read back.
    send(CMD_WR_ADDR, 8'h12, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'hA5, 0, 0, 0, 0);
    send(CMD_RD_ADDR, 8'h12, 0, 0, 0, 0);
    send(CMD_RD_DATA, 8'hEE, 1, 8'hA5, 1, 8'hA5);
    repeat (3) @(negedge clk);
    check("hold_dout", dout, 8'hA5);
    check("hold_tv", {7'd0, tx_valid}, 8'h01);

    // Back-to-back read.
`ifdef ADDR_AUTOINC_EN
    send(CMD_RD_DATA, 8'h00, 1, 8'h5A, 1, 8'h5A);
`else
    send(CMD_RD_DATA, 8'h00, 1, 8'hA5, 1, 8'hA5);
`endif

    // Any other command clears tx_valid.
    send(CMD_WR_ADDR, 8'h00, 0, 0, 0, 0);

    // Out of range only for the 200-deep instance.
    send(CMD_WR_ADDR, 8'hF0, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h55, 0, 0, 0, 0);
    send(CMD_RD_ADDR, 8'hF0, 0, 0, 0, 0);
    send(CMD_RD_DATA, 8'h00, 1, 8'h55, 1, 8'h00);
    send(CMD_RD_ADDR, 8'h28, 0, 0, 0, 0);
    send(CMD_RD_DATA, 8'h00, 1, 8'h3C, 1, 8'h3C);

    // Asynchronous reset while tx_valid is high.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_tv", {7'd0, tx_valid}, 8'h00);
    check("arst_dout2", dout2, 8'h00);
    check("arst_tv2", {7'd0, tx_valid2}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    send(CMD_RD_DATA, 8'h00, 1, 8'h77, 1, 8'h77);

    // Write pointer behaviour at the top of the array.
    send(CMD_WR_ADDR, 8'hFF, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h11, 0, 0, 0, 0);
    send(CMD_WR_DATA, 8'h22, 0, 0, 0, 0);
    send(CMD_RD_ADDR, 8'hFF, 0, 0, 0, 0);
`ifdef ADDR_AUTOINC_EN
    send(CMD_RD_DATA, 8'h00, 1, 8'h11, 1, 8'h00);
    send(CMD_RD_DATA, 8'h00, 1, 8'h22, 1, 8'h22);
`else
    send(CMD_RD_DATA, 8'h00, 1, 8'h22, 1, 8'h00);
    send(CMD_RD_ADDR, 8'h00, 0, 0, 0, 0);
    send(CMD_RD_DATA, 8'h00, 1, 8'h77, 1, 8'h77);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
